// File: rtl/swap_sort_pkg.sv
// Shared definitions for the swap-sort sequencer.
//   state_t     : controller FSM encoding (LOAD / SORT / DRAIN), 2 bits
//   SWAP_CNT_W  : width of the per-batch swap counter
//   idx_w()     : index width for a bank of a given depth (at least 1 bit)
package swap_sort_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SORT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int SWAP_CNT_W = 8;

  // A depth of 2 would give $clog2 = 1 anyway, but keep a floor of 1 bit
  // so a degenerate depth never produces a zero-width index.
  function automatic int idx_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/cmp_swap.sv
// Combinational compare-and-swap element.
//   a, b     : operands, unsigned WIDTH bits
//   ascend   : 1 = put the smaller value first, 0 = put the larger first
//   first    : value destined for the lower bank slot
//   second   : value destined for the higher bank slot
//   swapped  : high when the operands were exchanged
// Comparison is strict: equal operands never swap.
module cmp_swap #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ascend,
  output logic [WIDTH-1:0] first,
  output logic [WIDTH-1:0] second,
  output logic             swapped
);

  always_comb begin
    swapped = ascend ? (a > b) : (a < b);
    first   = swapped ? b : a;
    second  = swapped ? a : b;
  end

endmodule

// File: rtl/swap_sort_ctrl.sv
// Batch sorter: loads DEPTH words, bubble-sorts them in place with one
// compare-and-swap per clock (early exit on a swap-free pass), then drains
// them in order.
//   clk, rst_n  : clock, asynchronous active-low reset
//   in_valid/in_ready/in_data     : load port
//   out_valid/out_ready/out_data  : drain port, out_data = mem[rd_idx]
//   busy        : high while sorting
//   swap_count  : swaps performed on the current batch (saturating)
//   dbg_state   : current FSM state, for observation only
//
// Handshakes: a word moves on a rising edge where valid && ready are both
// high. in_ready and out_valid depend only on state, never on the partner's
// valid/ready, and a valid word's data is held stable until it is accepted.
module swap_sort_ctrl
  import swap_sort_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int DEPTH  = 8,
  parameter int ASCEND = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  busy,
  output logic [SWAP_CNT_W-1:0] swap_count,
  output state_t                dbg_state
);

  localparam int   IW  = idx_w(DEPTH);
  localparam logic ASC = (ASCEND != 0);

  localparam logic [IW-1:0] LAST_IDX  = IW'(DEPTH - 1);
  localparam logic [IW-1:0] LAST_PASS = IW'(DEPTH - 2);

  state_t state, state_nxt;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [IW-1:0]    wr_idx;
  logic [IW-1:0]    rd_idx;
  logic [IW-1:0]    j;
  logic [IW-1:0]    pass;
  logic             pass_swapped;

  logic [IW-1:0]    j_nxt;
  logic [IW-1:0]    last_j;
  logic             end_pass;
  logic             sort_done;
  logic             load_fire;
  logic             drain_fire;
  logic [WIDTH-1:0] cs_first;
  logic [WIDTH-1:0] cs_second;
  logic             cs_swapped;

  assign j_nxt      = j + IW'(1);
  // Pass p shrinks by one slot each time: the largest remaining value has
  // already bubbled to the end.
  assign last_j     = LAST_PASS - pass;
  assign end_pass   = (j == last_j);
  // The current compare counts toward "this pass swapped".
  assign sort_done  = end_pass && (!(pass_swapped || cs_swapped) || (pass == LAST_PASS));
  assign load_fire  = in_valid && in_ready;
  assign drain_fire = out_valid && out_ready;

  cmp_swap #(.WIDTH(WIDTH)) u_cmp_swap (
    .a       (mem[j]),
    .b       (mem[j_nxt]),
    .ascend  (ASC),
    .first   (cs_first),
    .second  (cs_second),
    .swapped (cs_swapped)
  );

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    unique case (state)
      LOAD:    if (load_fire && (wr_idx == LAST_IDX))   state_nxt = SORT;
      SORT:    if (sort_done)                           state_nxt = DRAIN;
      DRAIN:   if (drain_fire && (rd_idx == LAST_IDX))  state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready  = (state == LOAD);
    out_valid = (state == DRAIN);
    busy      = (state == SORT);
    // Gated so the port reads zero outside DRAIN (bank is not reset).
    out_data  = (state == DRAIN) ? mem[rd_idx] : '0;
    dbg_state = state;
  end

  // Indices, pass bookkeeping and swap counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx       <= '0;
      rd_idx       <= '0;
      j            <= '0;
      pass         <= '0;
      pass_swapped <= 1'b0;
      swap_count   <= '0;
    end else begin
      unique case (state)
        LOAD: begin
          if (load_fire) begin
            if (wr_idx == '0) swap_count <= '0;
            if (wr_idx == LAST_IDX) begin
              wr_idx       <= '0;
              j            <= '0;
              pass         <= '0;
              pass_swapped <= 1'b0;
            end else begin
              wr_idx <= wr_idx + IW'(1);
            end
          end
        end
        SORT: begin
          if (cs_swapped) begin
            pass_swapped <= 1'b1;
            if (swap_count != {SWAP_CNT_W{1'b1}}) swap_count <= swap_count + 1'b1;
          end
          if (end_pass) begin
            if (!sort_done) begin
              pass         <= pass + IW'(1);
              j            <= '0;
              pass_swapped <= 1'b0;
            end
          end else begin
            j <= j_nxt;
          end
        end
        DRAIN: begin
          if (drain_fire) begin
            if (rd_idx == LAST_IDX) rd_idx <= '0;
            else                    rd_idx <= rd_idx + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Register bank: contents are meaningless until loaded, so no reset.
  always_ff @(posedge clk) begin
    if (load_fire) mem[wr_idx] <= in_data;
    if (busy && cs_swapped) begin
      mem[j]     <= cs_first;
      mem[j_nxt] <= cs_second;
    end
  end

endmodule

// File: tb/tb_swap_sort_ctrl.sv
module tb_swap_sort_ctrl;
  import swap_sort_pkg::*;

  localparam int W = 4;
  localparam int D = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // shared stimulus, steered to one instance by use_desc
  logic         use_desc;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         out_ready;

  logic         in_valid_a, in_valid_d, out_ready_a, out_ready_d;
  logic         in_ready_a, in_ready_d, out_valid_a, out_valid_d, busy_a, busy_d;
  logic [W-1:0] out_data_a, out_data_d;
  logic [7:0]   swap_count_a, swap_count_d;
  state_t       dbg_state_a, dbg_state_d;

  assign in_valid_a  = in_valid  & ~use_desc;
  assign in_valid_d  = in_valid  &  use_desc;
  assign out_ready_a = out_ready & ~use_desc;
  assign out_ready_d = out_ready &  use_desc;

  logic         in_ready_m, out_valid_m, busy_m;
  logic [W-1:0] out_data_m;
  logic [7:0]   swap_count_m;
  state_t       dbg_state_m;
  assign in_ready_m   = use_desc ? in_ready_d   : in_ready_a;
  assign out_valid_m  = use_desc ? out_valid_d  : out_valid_a;
  assign busy_m       = use_desc ? busy_d       : busy_a;
  assign out_data_m   = use_desc ? out_data_d   : out_data_a;
  assign swap_count_m = use_desc ? swap_count_d : swap_count_a;
  assign dbg_state_m  = use_desc ? dbg_state_d  : dbg_state_a;

  swap_sort_ctrl #(.WIDTH(W), .DEPTH(D), .ASCEND(1)) u_asc (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a),
    .busy(busy_a), .swap_count(swap_count_a), .dbg_state(dbg_state_a)
  );

  swap_sort_ctrl #(.WIDTH(W), .DEPTH(D), .ASCEND(0)) u_desc (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_d), .in_ready(in_ready_d), .in_data(in_data),
    .out_valid(out_valid_d), .out_ready(out_ready_d), .out_data(out_data_d),
    .busy(busy_d), .swap_count(swap_count_d), .dbg_state(dbg_state_d)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int vectors = 0;
  int errors  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // All tasks start and end at a falling edge.
  task automatic send(input logic [W-1:0] d, input int gap);
    int n = 0;
    in_data  = d;
    in_valid = 1'b1;
    while (!in_ready_m && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("send_ready", in_ready_m, 1);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 4'hA;
    repeat (gap) @(negedge clk);
  endtask

  task automatic load4(input logic [W-1:0] v0, input logic [W-1:0] v1,
                       input logic [W-1:0] v2, input logic [W-1:0] v3);
    send(v0, 0);
    send(v1, 0);
    send(v2, 0);
    send(v3, 0);
  endtask

  task automatic push4(input logic [W-1:0] v0, input logic [W-1:0] v1,
                       input logic [W-1:0] v2, input logic [W-1:0] v3);
    exp_q.push_back(v0);
    exp_q.push_back(v1);
    exp_q.push_back(v2);
    exp_q.push_back(v3);
  endtask

  task automatic run_sort(input string tag, input int exp_cycles);
    int n = 0;
    while (busy_m && n < 100) begin
      n++;
      @(negedge clk);
    end
    check(tag, n, exp_cycles);
    check({tag, "_outv"}, out_valid_m, 1);
  endtask

  task automatic drain_all(input string tag);
    int n;
    logic [W-1:0] e;
    for (int i = 0; i < D; i++) begin
      n = 0;
      out_ready = 1'b1;
      while (!out_valid_m && n < 50) begin
        @(negedge clk);
        n++;
      end
      e = exp_q.pop_front();
      check(tag, out_data_m, e);
      @(negedge clk);
    end
    out_ready = 1'b0;
    check({tag, "_in_ready"}, in_ready_m, 1);
    check({tag, "_outv_low"}, out_valid_m, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int got;
    logic tgl;
    logic [W-1:0] e;

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; use_desc = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready_m, 1);
    check("rst_out_valid", out_valid_m, 0);
    check("rst_busy", busy_m, 0);
    check("rst_out_data", out_data_m, 0);
    check("rst_swap_count", swap_count_m, 0);
    check("rst_state", dbg_state_m, LOAD);
    rst_n = 1'b1;
    @(negedge clk);

    // 3,1,2,0 ascending: 6 compares, 5 swaps
    load4(3, 1, 2, 0);
    check("t1_busy", busy_m, 1);
    run_sort("t1_cycles", 6);
    push4(0, 1, 2, 3);
    drain_all("t1_data");
    check("t1_swaps", swap_count_m, 5);

    // already sorted: single pass, early exit
    load4(0, 1, 2, 3);
    run_sort("t2_cycles", 3);
    push4(0, 1, 2, 3);
    drain_all("t2_data");
    check("t2_swaps", swap_count_m, 0);

    // all equal: strict compare never swaps
    load4(5, 5, 5, 5);
    run_sort("t3_cycles", 3);
    push4(5, 5, 5, 5);
    drain_all("t3_data");
    check("t3_swaps", swap_count_m, 0);

    // descending instance: 1,9,4,15 -> 15,9,4,1 in 6 compares, 5 swaps
    use_desc = 1'b1;
    load4(1, 9, 4, 15);
    run_sort("t4_cycles", 6);
    push4(15, 9, 4, 1);
    drain_all("t4_data");
    check("t4_swaps", swap_count_m, 5);
    use_desc = 1'b0;

    // drain backpressure
    load4(3, 1, 2, 0);
    run_sort("t5_cycles", 6);
    for (int i = 0; i < 5; i++) begin
      check("t5_hold_data", out_data_m, 0);
      check("t5_hold_valid", out_valid_m, 1);
      @(negedge clk);
    end
    push4(0, 1, 2, 3);
    tgl = 1'b0; got = 0; n = 0;
    while (got < D && n < 40) begin
      out_ready = tgl;
      if (tgl && out_valid_m) begin
        e = exp_q.pop_front();
        check("t5_data", out_data_m, e);
        got++;
      end
      @(negedge clk);
      tgl = ~tgl;
      n++;
    end
    out_ready = 1'b0;
    check("t5_got", got, D);
    check("t5_in_ready", in_ready_m, 1);
    check("t5_swaps", swap_count_m, 5);

    // asynchronous reset during the second SORT cycle
    load4(3, 1, 2, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_in_ready", in_ready_m, 1);
    check("t6_busy", busy_m, 0);
    check("t6_out_valid", out_valid_m, 0);
    check("t6_swaps", swap_count_m, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_no_output", out_valid_m, 0);
    load4(2, 0, 3, 1);
    run_sort("t6_cycles", 6);
    push4(0, 1, 2, 3);
    drain_all("t6_data");
    check("t6_swaps_after", swap_count_m, 3);

    // load gaps; in_valid held high with junk during SORT must be ignored
    send(7, 2);
    send(3, 1);
    send(9, 3);
    send(1, 0);
    check("t7_busy_next", busy_m, 1);
    in_valid = 1'b1;
    in_data  = 4'hF;
    run_sort("t7_cycles", 6);
    in_valid = 1'b0;
    push4(1, 3, 7, 9);
    drain_all("t7_data");
    check("t7_swaps", swap_count_m, 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
